// File: rtl/spi_flash_loader.sv
// SPI flash READ (0x03) sequencer: streams byte_count bytes starting at flash_addr
// into a RAM write port starting at dest_addr. Mode 0, MSB first.
module spi_flash_loader #(
   parameter int CLK_DIV = 2,
   parameter int ADDR_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [23:0]       flash_addr,
   input  logic [15:0]       byte_count,
   input  logic [ADDR_W-1:0] dest_addr,
   output logic              busy,
   output logic              done,
   output logic              spi_cs_n,
   output logic              spi_sclk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CS_SETUP = 3'd1,
      CMD      = 3'd2,
      DATA     = 3'd3,
      CS_HOLD  = 3'd4,
      FINISH   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic              pend_q, pend_d;
   logic [31:0]       tx_q, tx_d;
   logic [7:0]        rx_q, rx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [5:0]        bit_q, bit_d;
   logic [15:0]       rem_q, rem_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rdy_q, rdy_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              cs_n_q, cs_n_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              wrap_s;

   assign wrap_s = (cnt_q == CNT_LAST);

   // Next-state and registered-output logic for the transfer sequencer and bit engine
   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      rem_d     = rem_q;
      addr_d    = addr_q;
      rdy_d     = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cs_n_d    = cs_n_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      wr_en_d   = rdy_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      // A completed byte is written one cycle after its 8th rising edge
      if (rdy_q) begin
         wr_addr_d = addr_q;
         wr_data_d = rx_q;
         addr_d    = addr_q + ADDR_W'(1);
      end else begin
         wr_addr_d = wr_addr_q;
      end

      case (state_q)
         IDLE: begin
            if (pend_q) begin
               pend_d = 1'b0;
               busy_d = 1'b1;
               cnt_d  = '0;
               if (rem_q == 16'd0) begin
                  state_d = FINISH;
               end else begin
                  state_d = CS_SETUP;
                  cs_n_d  = 1'b0;
                  sclk_d  = 1'b0;
                  mosi_d  = tx_q[31];
               end
            end else if (start) begin
               pend_d = 1'b1;
               tx_d   = {8'h03, flash_addr};
               rem_d  = byte_count;
               addr_d = dest_addr;
               bit_d  = 6'd0;
            end else begin
               pend_d = 1'b0;
            end
         end
         CS_SETUP: begin
            if (wrap_s) begin
               cnt_d   = '0;
               sclk_d  = 1'b1;
               rx_d    = {rx_q[6:0], spi_miso};
               state_d = CMD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         CMD, DATA: begin
            if (!wrap_s) begin
               cnt_d = cnt_q + CW'(1);
            end else if (!sclk_q) begin
               cnt_d  = '0;
               sclk_d = 1'b1;
               rx_d   = {rx_q[6:0], spi_miso};
               if (state_q == DATA) begin
                  bit_d = {3'b000, bit_q[2:0] + 3'd1};
                  if (bit_q[2:0] == 3'd7) begin
                     rdy_d = 1'b1;
                     rem_d = rem_q - 16'd1;
                  end else begin
                     rdy_d = 1'b0;
                  end
               end else begin
                  bit_d = bit_q;
               end
            end else begin
               cnt_d  = '0;
               sclk_d = 1'b0;
               tx_d   = {tx_q[30:0], 1'b0};
               if (state_q == CMD) begin
                  if (bit_q == 6'd31) begin
                     state_d = DATA;
                     bit_d   = 6'd0;
                     mosi_d  = 1'b0;
                  end else begin
                     bit_d  = bit_q + 6'd1;
                     mosi_d = tx_q[30];
                  end
               end else if ((bit_q[2:0] == 3'd0) && (rem_q == 16'd0)) begin
                  // bit_q wraps to 0 only after a byte's 8th rise, so this is the last byte's last fall
                  state_d = CS_HOLD;
                  mosi_d  = 1'b0;
               end else begin
                  mosi_d = 1'b0;
               end
            end
         end
         CS_HOLD: begin
            if (wrap_s) begin
               cnt_d   = '0;
               cs_n_d  = 1'b1;
               state_d = FINISH;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         pend_q    <= 1'b0;
         tx_q      <= 32'd0;
         rx_q      <= 8'd0;
         cnt_q     <= '0;
         bit_q     <= 6'd0;
         rem_q     <= 16'd0;
         addr_q    <= '0;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         rem_q     <= rem_d;
         addr_q    <= addr_d;
         rdy_q     <= rdy_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cs_n_q    <= cs_n_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign spi_cs_n = cs_n_q;
   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_spi_flash_loader.sv
// Bench for spi_flash_loader: an SPI flash responder plus a bus monitor; expected
// timing and write traffic come from the READ protocol rules in plain arithmetic.
module tb_spi_flash_loader;
   localparam int CD = 2;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [23:0]   flash_addr = 24'd0;
   logic [15:0]   byte_count = 16'd0;
   logic [AW-1:0] dest_addr = '0;
   logic          spi_miso = 1'b0;
   logic          busy, done, spi_cs_n, spi_sclk, spi_mosi, wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;

   spi_flash_loader #(.CLK_DIV(CD), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .flash_addr(flash_addr),
      .byte_count(byte_count), .dest_addr(dest_addr), .busy(busy), .done(done),
      .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_fail = 0;

   // monitor state: everything observed on the bus since the last clear_mon
   int            rises_q[$];
   bit            mosi_q[$];
   logic [AW+7:0] wr_q[$];
   int            wr_edge_q[$];
   logic [7:0]    fbytes[$];
   int falls, last_fall, cs_fall, cs_rise, done_cnt, done_edge, cs_bad;
   logic prev_sclk = 1'b0, prev_cs = 1'b1;

   always @(negedge clk) begin : monitor
      int idx, j;
      logic [7:0] fb;
      if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
         rises_q.push_back(cyc);
         mosi_q.push_back(spi_mosi);
         if (spi_cs_n !== 1'b0) cs_bad++;
      end
      if (spi_sclk === 1'b0 && prev_sclk === 1'b1) begin
         falls++;
         last_fall = cyc;
      end
      if (spi_cs_n === 1'b0 && prev_cs === 1'b1) cs_fall = cyc;
      if (spi_cs_n === 1'b1 && prev_cs === 1'b0) cs_rise = cyc;
      if (wr_en === 1'b1) begin
         wr_q.push_back({wr_addr, wr_data});
         wr_edge_q.push_back(cyc);
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_edge = cyc;
      end
      prev_sclk = spi_sclk;
      prev_cs   = spi_cs_n;
      // flash responder: present the bit the next rising edge will sample
      idx = rises_q.size();
      spi_miso = 1'b0;
      if (idx >= 32) begin
         j = (idx - 32) / 8;
         if (j < fbytes.size()) begin
            fb = fbytes[j];
            spi_miso = fb[7 - ((idx - 32) % 8)];
         end
      end
   end

   task automatic clear_mon;
      rises_q.delete(); mosi_q.delete(); wr_q.delete(); wr_edge_q.delete();
      falls = 0; last_fall = -1; cs_fall = -1; cs_rise = -1;
      done_cnt = 0; done_edge = -1; cs_bad = 0;
   endtask

   // Pulses start for one cycle; t is the clk edge that samples it
   task automatic do_start(input logic [23:0] fa, input logic [15:0] n,
                           input logic [AW-1:0] da, output int t);
      flash_addr = fa; byte_count = n; dest_addr = da; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = cyc;
      flash_addr = 24'($urandom); byte_count = 16'($urandom); dest_addr = AW'($urandom);
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done_cnt > 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic logic [31:0] cmd_word();
      logic [31:0] w = 32'd0;
      for (int i = 0; i < 32; i++) w = {w[30:0], (i < mosi_q.size()) ? mosi_q[i] : 1'b0};
      return w;
   endfunction

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, spi_cs_n, spi_sclk, spi_mosi, wr_en, wr_addr, wr_data} !==
          {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_values: got busy=%b done=%b cs_n=%b sclk=%b mosi=%b wr_en=%b wr_addr=%h wr_data=%h, want 0 0 1 0 0 0 0000 00",
                  busy, done, spi_cs_n, spi_sclk, spi_mosi, wr_en, wr_addr, wr_data);
      end
      reset = 1'b1;
      clear_mon();
      repeat (5) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || spi_cs_n !== 1'b1 || rises_q.size() != 0) begin
         n_fail++;
         $display("FAIL idle_quiet: got busy=%b cs_n=%b rises=%0d, want 0 1 0", busy, spi_cs_n, rises_q.size());
      end
   endtask

   task automatic test_cmd_framing;
      int t; bit ok;
      clear_mon();
      fbytes = '{8'h5A};
      do_start(24'h012345, 16'd1, 16'h0100, t);
      wait_done(2000, ok);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL framing_timeout: no done within budget"); end
      n_cmp++;
      if (cmd_word() !== 32'h03012345) begin
         n_fail++; $display("FAIL framing_cmd: got %h want 03012345", cmd_word());
      end
      n_cmp++;
      if (rises_q.size() != 40) begin
         n_fail++; $display("FAIL framing_rises: got %0d want 40", rises_q.size());
      end
      n_cmp++;
      if (cs_bad != 0 || cs_fall != t + 1 || cs_rise != last_fall + CD) begin
         n_fail++;
         $display("FAIL framing_cs: bad=%0d fall=%0d rise=%0d, want 0 %0d %0d", cs_bad, cs_fall, cs_rise, t + 1, last_fall + CD);
      end
   endtask

   task automatic test_data_path;
      int t; bit ok;
      logic [AW+7:0] exp_w[3];
      exp_w = '{{16'hE000, 8'hA5}, {16'hE001, 8'h3C}, {16'hE002, 8'hFF}};
      clear_mon();
      fbytes = '{8'hA5, 8'h3C, 8'hFF};
      do_start(24'h00C000, 16'd3, 16'hE000, t);
      wait_done(3000, ok);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (!ok || done_cnt != 1) begin
         n_fail++; $display("FAIL data_done: ok=%0b done_cnt=%0d want 1 1", ok, done_cnt);
      end
      n_cmp++;
      if (wr_q.size() != 3) begin
         n_fail++; $display("FAIL data_wr_count: got %0d want 3", wr_q.size());
      end
      for (int j = 0; j < 3; j++) begin
         logic [AW+7:0] got;
         got = (j < wr_q.size()) ? wr_q[j] : 'x;
         n_cmp++;
         if (got !== exp_w[j]) begin
            n_fail++; $display("FAIL data_write%0d: got %h want %h", j, got, exp_w[j]);
         end
      end
   endtask

   task automatic test_addr_wrap;
      int t; bit ok;
      logic [AW+7:0] g0, g1;
      clear_mon();
      fbytes = '{8'h12, 8'h34};
      do_start(24'hFFFFF0, 16'd2, 16'hFFFF, t);
      wait_done(3000, ok);
      repeat (3) @(negedge clk);
      g0 = (wr_q.size() > 0) ? wr_q[0] : 'x;
      g1 = (wr_q.size() > 1) ? wr_q[1] : 'x;
      n_cmp++;
      if (!ok || wr_q.size() != 2 || g0 !== {16'hFFFF, 8'h12} || g1 !== {16'h0000, 8'h34}) begin
         n_fail++;
         $display("FAIL addr_wrap: ok=%0b n=%0d w0=%h w1=%h want 1 2 ffff12 000034", ok, wr_q.size(), g0, g1);
      end
   endtask

   task automatic test_zero_len;
      int t; bit ok;
      clear_mon();
      fbytes.delete();
      do_start(24'h123456, 16'd0, 16'h4000, t);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || spi_cs_n !== 1'b1) begin
         n_fail++; $display("FAIL zero_busy: busy=%b cs_n=%b want 1 1", busy, spi_cs_n);
      end
      wait_done(50, ok);
      repeat (5) @(negedge clk);
      n_cmp++;
      if (!ok || done_edge != t + 2 || done_cnt != 1) begin
         n_fail++; $display("FAIL zero_done: edge=%0d cnt=%0d want %0d 1", done_edge, done_cnt, t + 2);
      end
      n_cmp++;
      if (cs_fall != -1 || rises_q.size() != 0 || falls != 0 || wr_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_quiet: cs_fall=%0d rises=%0d falls=%0d wr=%0d busy=%b want -1 0 0 0 0",
                  cs_fall, rises_q.size(), falls, wr_q.size(), busy);
      end
   endtask

   task automatic test_start_while_busy;
      int t; bit ok;
      logic [AW+7:0] g0, g1;
      clear_mon();
      fbytes = '{8'h11, 8'h22};
      do_start(24'hABCDEF, 16'd2, 16'h1000, t);
      for (int i = 0; i < 200 && rises_q.size() < 10; i++) @(negedge clk);
      flash_addr = 24'h555555; byte_count = 16'd7; dest_addr = 16'h2222; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(3000, ok);
      repeat (20) @(negedge clk);
      g0 = (wr_q.size() > 0) ? wr_q[0] : 'x;
      g1 = (wr_q.size() > 1) ? wr_q[1] : 'x;
      n_cmp++;
      if (cmd_word() !== 32'h03ABCDEF) begin
         n_fail++; $display("FAIL busy_start_cmd: got %h want 03abcdef", cmd_word());
      end
      n_cmp++;
      if (!ok || done_cnt != 1 || rises_q.size() != 48 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_start_len: ok=%0b done=%0d rises=%0d busy=%b want 1 1 48 0", ok, done_cnt, rises_q.size(), busy);
      end
      n_cmp++;
      if (wr_q.size() != 2 || g0 !== {16'h1000, 8'h11} || g1 !== {16'h1001, 8'h22}) begin
         n_fail++; $display("FAIL busy_start_wr: n=%0d w0=%h w1=%h want 2 100011 100122", wr_q.size(), g0, g1);
      end
   endtask

   task automatic test_reset_mid_data;
      int t; bit ok;
      logic [AW+7:0] g0, g1;
      clear_mon();
      fbytes = '{8'h01, 8'h02, 8'h03, 8'h04};
      do_start(24'h000400, 16'd4, 16'h3000, t);
      for (int i = 0; i < 1000 && rises_q.size() < 43; i++) @(negedge clk);
      n_cmp++;
      if (rises_q.size() != 43) begin
         n_fail++; $display("FAIL rst_reach_byte2: rises=%0d want 43", rises_q.size());
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({spi_cs_n, spi_sclk, busy, done, wr_en} !== 5'b10000) begin
         n_fail++;
         $display("FAIL rst_abort: cs_n=%b sclk=%b busy=%b done=%b wr_en=%b want 1 0 0 0 0", spi_cs_n, spi_sclk, busy, done, wr_en);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (done_cnt != 0 || spi_cs_n !== 1'b1) begin
         n_fail++; $display("FAIL rst_no_done: done_cnt=%0d cs_n=%b want 0 1", done_cnt, spi_cs_n);
      end
      clear_mon();
      fbytes = '{8'hC3, 8'h7E};
      do_start(24'h00D000, 16'd2, 16'hD000, t);
      wait_done(3000, ok);
      repeat (3) @(negedge clk);
      g0 = (wr_q.size() > 0) ? wr_q[0] : 'x;
      g1 = (wr_q.size() > 1) ? wr_q[1] : 'x;
      n_cmp++;
      if (!ok || cmd_word() !== 32'h0300D000 || wr_q.size() != 2 || g0 !== {16'hD000, 8'hC3} || g1 !== {16'hD001, 8'h7E}) begin
         n_fail++;
         $display("FAIL rst_restart: ok=%0b cmd=%h n=%0d w0=%h w1=%h want 1 0300d000 2 d000c3 d0017e",
                  ok, cmd_word(), wr_q.size(), g0, g1);
      end
   endtask

   task automatic test_random;
      for (int it = 0; it < 6; it++) begin
         logic [23:0] fa;
         logic [15:0] n;
         logic [AW-1:0] da;
         logic [AW+7:0] got, expw;
         int t, b, exp_last_fall;
         bit ok;
         fa = 24'($urandom);
         n  = 16'($urandom_range(1, 5));
         da = (it == 0) ? 16'hFFFE : AW'($urandom);
         fbytes.delete();
         for (int j = 0; j < int'(n); j++) fbytes.push_back(8'($urandom));
         clear_mon();
         do_start(fa, n, da, t);
         @(negedge clk);
         n_cmp++;
         if (busy !== 1'b1 || spi_cs_n !== 1'b0) begin
            n_fail++; $display("FAIL rnd%0d_start: busy=%b cs_n=%b want 1 0", it, busy, spi_cs_n);
         end
         wait_done(4000, ok);
         repeat (3) @(negedge clk);
         b = 32 + 8 * int'(n);
         exp_last_fall = t + 1 + CD + (2 * b - 1) * CD;
         n_cmp++;
         if (!ok || done_cnt != 1) begin
            n_fail++; $display("FAIL rnd%0d_done: ok=%0b cnt=%0d want 1 1", it, ok, done_cnt);
         end
         n_cmp++;
         if (cmd_word() !== {8'h03, fa}) begin
            n_fail++; $display("FAIL rnd%0d_cmd: got %h want %h", it, cmd_word(), {8'h03, fa});
         end
         n_cmp++;
         if (rises_q.size() != b || falls != b || cs_bad != 0) begin
            n_fail++; $display("FAIL rnd%0d_edges: rises=%0d falls=%0d bad=%0d want %0d %0d 0", it, rises_q.size(), falls, cs_bad, b, b);
         end
         for (int k = 0; k < b; k++) begin
            int gr;
            gr = (k < rises_q.size()) ? rises_q[k] : -1;
            n_cmp++;
            if (gr != t + 1 + CD + 2 * k * CD) begin
               n_fail++; $display("FAIL rnd%0d_rise%0d: got %0d want %0d", it, k, gr, t + 1 + CD + 2 * k * CD);
               break;
            end
         end
         n_cmp++;
         if (cs_fall != t + 1 || last_fall != exp_last_fall || cs_rise != exp_last_fall + CD || done_edge != exp_last_fall + CD + 1) begin
            n_fail++;
            $display("FAIL rnd%0d_frame: csf=%0d lf=%0d csr=%0d done=%0d want %0d %0d %0d %0d", it, cs_fall, last_fall,
                     cs_rise, done_edge, t + 1, exp_last_fall, exp_last_fall + CD, exp_last_fall + CD + 1);
         end
         n_cmp++;
         if (wr_q.size() != int'(n)) begin
            n_fail++; $display("FAIL rnd%0d_wr_count: got %0d want %0d", it, wr_q.size(), n);
         end
         for (int j = 0; j < int'(n); j++) begin
            int ge;
            expw = {da + AW'(j), fbytes[j]};
            got  = (j < wr_q.size()) ? wr_q[j] : 'x;
            ge   = (j < wr_edge_q.size()) ? wr_edge_q[j] : -1;
            n_cmp++;
            if (got !== expw || ge != t + 1 + CD + 2 * (32 + 8 * j + 7) * CD + 1) begin
               n_fail++;
               $display("FAIL rnd%0d_write%0d: got %h @%0d want %h @%0d", it, j, got, ge, expw,
                        t + 1 + CD + 2 * (32 + 8 * j + 7) * CD + 1);
            end
         end
      end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_cmd_framing();
      test_data_path();
      test_addr_wrap();
      test_zero_len();
      test_start_while_busy();
      test_reset_mid_data();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_flash_loader.md
# spi_flash_loader

Sequencing master that sits directly upstream of the C64 memory map and drives the SPI flash link. On a start pulse it issues a standard READ (0x03) command with a 24-bit flash address, then streams a programmed number of bytes back from the flash. Each received byte is presented as a single-cycle write on a RAM write port, so ROM images (KERNAL, BASIC, CHARGEN) are copied into block RAM at boot. It replaces the fixed-command bring-up shifter for all image-load traffic.

## Interface
- CLK_DIV, 2: SPI half-period in clk cycles (≥1); one bit time = 2·CLK_DIV clk cycles
- ADDR_W, 16: width of the destination RAM address

- clk  in  1  system clock; all logic on posedge clk
- reset  in  1  reset, synchronous, active-low
- start  in  1  single-cycle request; sampled only in IDLE
- flash_addr  in  24  flash start address, latched on accepted start
- byte_count  in  16  number of bytes to read, latched on accepted start
- dest_addr  in  ADDR_W  RAM address of first byte, latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse at end of transfer
- spi_cs_n  out  1  flash chip select, active-low
- spi_sclk  out  1  SPI clock, mode 0 (idle low)
- spi_mosi  out  1  command/address data, MSB first
- spi_miso  in  1  flash read data
- wr_en  out  1  single-cycle RAM write strobe
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  8  RAM write data

## Operation
- Reset values (reset low at a clk edge): state IDLE, busy 0, done 0, spi_cs_n 1, spi_sclk 0, spi_mosi 0, wr_en 0, wr_addr 0, wr_data 0. Reset mid-transfer aborts immediately: CS deasserts on that edge, no done pulse.
- States: IDLE → CS_SETUP → CMD → DATA → CS_HOLD → FINISH → IDLE.
- IDLE: start=1 latches inputs and loads a 32-bit tx shift register with {8'h03, flash_addr}. If byte_count=0, go to FINISH (CS never asserts). Otherwise go to CS_SETUP.
- start while busy: ignored, no effect on the transfer in progress.
- CS_SETUP: spi_cs_n=0, spi_mosi=tx[31], sclk low. Lasts CLK_DIV cycles, then CMD.
- Bit engine, shared by CMD and DATA: half-period counter 0..CLK_DIV-1.
  - On wrap with sclk low: sclk rises and spi_miso is sampled into the rx shift register.
  - On wrap with sclk high: sclk falls and the tx register shifts, driving the next MOSI bit.
- CMD: 32 bits. After the 32nd falling edge, go to DATA. MOSI is 0 throughout DATA.
- DATA: 8 bits per byte, MSB first. On the clk edge after the 8th rising edge of a byte:
  - wr_en=1 for one cycle;
  - wr_data = the assembled byte;
  - wr_addr = dest_addr + byte index, modulo 2^ADDR_W (wraps silently).
- After the last byte's 8th falling edge, go to CS_HOLD. Sclk stays low for CLK_DIV cycles, then spi_cs_n=1 and the FSM goes to FINISH.
- FINISH: done=1 for one cycle, busy=0 on the same edge, then IDLE.
- byte_count is 16-bit: a maximum of 65535 bytes per start.

## Timing
- Accepted start at edge T: busy=1 and spi_cs_n=0 at T+1.
- First sclk rise: T+1+CLK_DIV.
- Bit k rises at T+1+CLK_DIV+2k·CLK_DIV (k=0..), for k = 0 .. 32+8N−1.
- wr_en for byte j (0-based) is one clk cycle after the rise of bit 32+8j+7.
- Last falling edge at T+1+CLK_DIV+(2(32+8N)−1)·CLK_DIV.
- spi_cs_n rises CLK_DIV cycles after the last falling edge. done pulses on the following edge.
- Bus-free minimum: CS high ≥1 clk before the next start can assert CS (FINISH plus IDLE).
- MOSI changes only on sclk falling edges (or on CS assertion). MISO is sampled only on rising edges.

## Test plan
- Command framing: CLK_DIV=2, flash_addr=0x012345, byte_count=1 → MOSI bits on the first 32 rises read 0x03012345; exactly 40 sclk rises; CS low the whole time.
- Data path: flash model returns 0xA5, 0x3C, 0xFF, dest_addr=0xE000, N=3 → writes (0xE000,0xA5), (0xE001,0x3C), (0xE002,0xFF); one wr_en cycle each; done once.
- Address wrap: dest_addr=0xFFFF, N=2 → wr_addr sequence 0xFFFF then 0x0000.
- Zero length: byte_count=0 → done at T+2, spi_cs_n stays 1, no sclk edges, no wr_en.
- Start while busy: second start pulse mid-CMD with a different address → ignored; the original transfer completes unchanged.
- Reset mid-DATA: drive reset low during byte 2 of 4 → next edge gives spi_cs_n=1, sclk=0, busy=0, no done; a new start afterwards runs a full correct transfer.
